// File: rtl/scramble_ctrl.sv
// Colour-channel scramble stage: remaps the R/G/B channels of a handshaked pixel
// stream, with the remap select latched only on start-of-frame beats.
module scramble_ctrl #(
    parameter int AUTO_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  sw,
    input  logic        auto_en,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_data,
    output logic        m_sof,
    output logic [5:0]  active_sel
);

    localparam int               CNT_W     = $clog2(AUTO_FRAMES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(AUTO_FRAMES - 1);
    localparam logic [5:0]       SEL_IDENT = 6'b00_01_10;
    localparam logic [2:0]       IDX_LAST  = 3'd5;

    typedef enum logic {
        ST_SYNC,
        ST_RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       sw_p0;
    logic [5:0]       sw_p1;
    logic             auto_p0;
    logic             auto_p1;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [2:0]       idx_inc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             was_auto;
    logic             was_auto_nxt;
    logic [5:0]       sel_nxt;
    logic             accept;
    logic             load;

    // Auto-mode permutation table; every entry is a true channel permutation.
    function automatic logic [5:0] perm_lut(input logic [2:0] i);
        logic [5:0] p;
        case (i)
            3'd0:    p = 6'b00_01_10;
            3'd1:    p = 6'b00_10_01;
            3'd2:    p = 6'b01_00_10;
            3'd3:    p = 6'b01_10_00;
            3'd4:    p = 6'b10_00_01;
            3'd5:    p = 6'b10_01_00;
            default: p = SEL_IDENT;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] pick(input logic [23:0] px, input logic [1:0] code);
        logic [7:0] c;
        case (code)
            2'b00:   c = px[23:16];
            2'b01:   c = px[15:8];
            2'b10:   c = px[7:0];
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [23:0] remap(input logic [23:0] px, input logic [5:0] sel);
        return {pick(px, sel[5:4]), pick(px, sel[3:2]), pick(px, sel[1:0])};
    endfunction

    // Two-flop synchronizers for the board-level controls
    always_ff @(posedge clk) begin
        sw_p0   <= sw;
        sw_p1   <= sw_p0;
        auto_p0 <= auto_en;
        auto_p1 <= auto_p0;
    end

    // In SYNC nothing is ever held in the output register, so input is always taken.
    assign s_ready = (state == ST_SYNC) || !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign load    = accept && ((state == ST_RUN) || s_sof);
    assign idx_inc = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;

    always_comb begin
        state_nxt    = state;
        sel_nxt      = active_sel;
        idx_nxt      = idx;
        cnt_nxt      = cnt;
        was_auto_nxt = was_auto;
        if (accept && s_sof) begin
            state_nxt = ST_RUN;
        end
        // sel_nxt is the mapping applied to the beat being loaded this cycle
        if (load && s_sof) begin
            if (!auto_p1) begin
                sel_nxt      = sw_p1;
                idx_nxt      = 3'd0;
                cnt_nxt      = '0;
                was_auto_nxt = 1'b0;
            end else if (!was_auto) begin
                sel_nxt      = perm_lut(3'd0);
                idx_nxt      = 3'd0;
                cnt_nxt      = '0;
                was_auto_nxt = 1'b1;
            end else if (cnt == CNT_LAST) begin
                sel_nxt = perm_lut(idx_inc);
                idx_nxt = idx_inc;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SYNC;
            m_valid    <= 1'b0;
            m_data     <= 24'h000000;
            m_sof      <= 1'b0;
            active_sel <= SEL_IDENT;
            idx        <= 3'd0;
            cnt        <= '0;
            was_auto   <= 1'b0;
        end else begin
            state      <= state_nxt;
            active_sel <= sel_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            was_auto   <= was_auto_nxt;
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= remap(s_data, sel_nxt);
                m_sof   <= s_sof;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scramble_ctrl.sv
// Directed bench for scramble_ctrl: frame sync, manual/auto select, backpressure, reset.
module tb_scramble_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  sw;
    logic        auto_en;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        s_sof;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;
    logic        m_sof;
    logic [5:0]  active_sel;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] auto_exp [13] = '{
        6'b00_01_10, 6'b00_01_10, 6'b00_10_01, 6'b00_10_01,
        6'b01_00_10, 6'b01_00_10, 6'b01_10_00, 6'b01_10_00,
        6'b10_00_01, 6'b10_00_01, 6'b10_01_00, 6'b10_01_00,
        6'b00_01_10
    };

    always #5 clk = ~clk;

    scramble_ctrl #(.AUTO_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .auto_en    (auto_en),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .active_sel (active_sel)
    );

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [23:0] d, input logic sof);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        step();
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        rst     = 1'b1;
        sw      = 6'b00_01_10;
        auto_en = 1'b0;
        s_valid = 1'b0;
        s_data  = 24'h0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        check("rst_m_valid", 24'(m_valid), 24'd0);
        check("rst_m_sof", 24'(m_sof), 24'd0);
        check("rst_m_data", m_data, 24'h000000);
        check("rst_s_ready", 24'(s_ready), 24'd1);
        check("rst_active_sel", 24'(active_sel), 24'(6'b00_01_10));
        rst = 1'b0;

        // Pre-sof beats are swallowed in SYNC
        for (int i = 0; i < 3; i++) begin
            beat(24'h0A0B0C, 1'b0);
            check("sync_discard_valid", 24'(m_valid), 24'd0);
        end
        beat(24'h112233, 1'b1);
        check("first_sof_data", m_data, 24'h112233);
        check("first_sof_sof", 24'(m_sof), 24'd1);
        check("first_sof_valid", 24'(m_valid), 24'd1);

        // Manual select, frozen mid-frame
        sw = 6'b10_01_00;
        idle(3);
        check("drain_valid", 24'(m_valid), 24'd0);
        beat(24'hAABBCC, 1'b1);
        check("man_sof_data", m_data, 24'hCCBBAA);
        check("man_sel", 24'(active_sel), 24'(6'b10_01_00));
        sw = 6'b11_11_11;
        beat(24'h123456, 1'b0);
        check("man_mid_data0", m_data, 24'h563412);
        check("man_mid_sof", 24'(m_sof), 24'd0);
        beat(24'h123456, 1'b0);
        beat(24'h123456, 1'b0);
        check("man_mid_data2", m_data, 24'h563412);
        check("man_mid_sel", 24'(active_sel), 24'(6'b10_01_00));
        beat(24'hAABBCC, 1'b1);
        check("man_zero_data", m_data, 24'h000000);
        check("man_zero_sel", 24'(active_sel), 24'(6'b11_11_11));

        // Backpressure: hold output, stall input, then stream at full rate
        sw = 6'b00_01_10;
        idle(3);
        m_ready = 1'b0;
        beat(24'h000001, 1'b1);
        check("bp_first_data", m_data, 24'h000001);
        check("bp_first_valid", 24'(m_valid), 24'd1);
        s_valid = 1'b1;
        s_data  = 24'h000002;
        s_sof   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_s_ready", 24'(s_ready), 24'd0);
            step();
            check("bp_hold_data", m_data, 24'h000001);
            check("bp_hold_valid", 24'(m_valid), 24'd1);
        end
        m_ready = 1'b1;
        #1;
        check("bp_release_ready", 24'(s_ready), 24'd1);
        step();
        check("bp_out_b", m_data, 24'h000002);
        s_data = 24'h000003;
        step();
        check("bp_out_c", m_data, 24'h000003);
        s_data = 24'h000004;
        step();
        check("bp_out_d", m_data, 24'h000004);
        check("bp_out_d_valid", 24'(m_valid), 24'd1);
        s_valid = 1'b0;
        step();
        check("bp_drained", 24'(m_valid), 24'd0);

        // Auto cycling, two frames per permutation
        auto_en = 1'b1;
        idle(3);
        for (int f = 0; f < 13; f++) begin
            beat(24'h010203, 1'b1);
            check($sformatf("auto_sel_f%0d", f + 1), 24'(active_sel), 24'(auto_exp[f]));
            if (f == 2) check("auto_f3_data", m_data, 24'h010302);
            if (f == 11) check("auto_f12_data", m_data, 24'h030201);
        end

        // Auto -> manual mid-frame, then back to auto
        beat(24'h010203, 1'b1);
        check("toggle_f14_sel", 24'(active_sel), 24'(6'b00_01_10));
        auto_en = 1'b0;
        sw      = 6'b10_01_00;
        for (int i = 0; i < 3; i++) begin
            beat(24'h010203, 1'b0);
            check("toggle_mid_data", m_data, 24'h010203);
        end
        beat(24'h010203, 1'b1);
        check("toggle_man_data", m_data, 24'h030201);
        check("toggle_man_sel", 24'(active_sel), 24'(6'b10_01_00));
        auto_en = 1'b1;
        idle(3);
        beat(24'h010203, 1'b1);
        check("reauto_sel0", 24'(active_sel), 24'(6'b00_01_10));
        check("reauto_data0", m_data, 24'h010203);
        beat(24'h010203, 1'b1);
        check("reauto_sel1", 24'(active_sel), 24'(6'b00_01_10));
        beat(24'h010203, 1'b1);
        check("reauto_sel2", 24'(active_sel), 24'(6'b00_10_01));
        check("reauto_data2", m_data, 24'h010302);

        // Reset mid-frame while the output is stalled
        auto_en = 1'b0;
        sw      = 6'b10_01_00;
        idle(3);
        beat(24'hAABBCC, 1'b1);
        check("rstmid_sof_data", m_data, 24'hCCBBAA);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 24'h111111;
        s_sof   = 1'b0;
        step();
        check("rstmid_hold_data", m_data, 24'hCCBBAA);
        check("rstmid_hold_valid", 24'(m_valid), 24'd1);
        rst = 1'b1;
        step();
        check("rstmid_valid", 24'(m_valid), 24'd0);
        check("rstmid_sel", 24'(active_sel), 24'(6'b00_01_10));
        check("rstmid_s_ready", 24'(s_ready), 24'd1);
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstmid_discard", 24'(m_valid), 24'd0);
        end
        beat(24'h123456, 1'b1);
        check("rstmid_resync_data", m_data, 24'h563412);
        check("rstmid_resync_sof", 24'(m_sof), 24'd1);
        check("rstmid_resync_sel", 24'(active_sel), 24'(6'b10_01_00));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
